tdm_demux4_rx: RTL



---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_slot_deser.sv | 56 +++++
 rtl/tdm_demux4_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Definitions shared by the 4-channel TDM transmitter and
//                receiver. These are the channel count, the slot index width
//                and the frame-alignment state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = $clog2(NUM_CH);

    // HUNT : waiting for a frame-sync strobe to establish alignment
    // LOCK : aligned; every accepted bit is steered into its slot
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_deser
//  Description : W-bit serial-to-parallel converter (MSB first) with a bit
//                counter. It flags the beat that completes a slot word.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_din           serial bit
//                i_shift         accept i_din as the next bit of the slot
//                i_restart       accept i_din as bit 0 of a new slot
//                                (takes priority over i_shift)
//                o_bit_cnt       index of the next bit expected in the slot
//                o_word_done     this beat completes the slot (comb)
//                o_word          completed word, valid with o_word_done (comb)
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_slot_deser #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_din,
    input  logic                 i_shift,
    input  logic                 i_restart,
    output logic [$clog2(W)-1:0] o_bit_cnt,
    output logic                 o_word_done,
    output logic [W-1:0]         o_word
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(W - 1);

    logic [W-1:0]     r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_restart) begin
            // The restarting bit is bit 0, so the next expected bit is 1.
            r_shreg   <= {r_shreg[W-2:0], i_din};
            r_bit_cnt <= CNT_W'(1);
        end else if (i_shift) begin
            r_shreg   <= {r_shreg[W-2:0], i_din};
            r_bit_cnt <= (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    // The final bit goes straight to the word. No extra cycle is spent
    // landing it in the shift register.
    assign o_word      = {r_shreg[W-2:0], i_din};
    assign o_word_done = i_shift && !i_restart && (r_bit_cnt == c_last_bit);
    assign o_bit_cnt   = r_bit_cnt;

endmodule : tdm_slot_deser
`default_nettype wire

// File: rtl/tdm_demux4_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux4_rx
//  Description : Receive-side 4-channel TDM demultiplexer. It aligns to the
//                frame-sync strobe and steers each W-bit slot onto its own
//                channel register. It reports slot and frame completion and
//                reports loss of alignment.
//  Ports       : clk, rst_n      clock / async active-low reset
//                din             serial data bit
//                din_valid       din/fsync qualifier (low = stall)
//                fsync           frame sync, marks slot 0 bit 0
//                ch_data         channel k at [k*W +: W]
//                ch_valid        per-slot update pulse
//                frame_valid     full aligned frame completed (with ch_valid[3])
//                locked          alignment held
//                sync_err        alignment error pulse
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux4_rx
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    input  logic                din_valid,
    input  logic                fsync,
    output logic [NUM_CH*W-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic                frame_valid,
    output logic                locked,
    output logic                sync_err
);

    localparam int CNT_W = $clog2(W);
    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_CH - 1);

    tdm_state_e        r_state;
    tdm_state_e        w_next_state;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [W-1:0]      r_ch_word [NUM_CH];
    logic [NUM_CH-1:0] r_ch_valid;
    logic              r_frame_valid;
    logic              r_sync_err;

    logic [CNT_W-1:0]  w_bit_cnt;
    logic              w_word_done;
    logic [W-1:0]      w_word;

    logic              w_at_start;
    logic              w_restart;
    logic              w_shift;
    logic              w_missing;
    logic              w_early;

    tdm_slot_deser #(
        .W (W)
    ) u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_din       (din),
        .i_shift     (w_shift),
        .i_restart   (w_restart),
        .o_bit_cnt   (w_bit_cnt),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and beat classification.
    // An accepted fsync always restarts the frame. In HUNT it acquires
    // alignment. At the frame start in LOCK it is normal. Anywhere else it
    // is an early sync that is reported and then re-aligned to.
    // Counters never leave the frame-start position in HUNT. The missing-sync
    // case therefore leaves them in the state that HUNT expects.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_at_start   = (w_bit_cnt == '0) && (r_slot_cnt == '0);
        w_restart    = din_valid && fsync;
        w_shift      = 1'b0;
        w_missing    = 1'b0;
        w_early      = 1'b0;

        case (r_state)
            HUNT: begin
                if (w_restart) begin
                    w_next_state = LOCK;
                end
            end
            LOCK: begin
                w_shift   = din_valid && !fsync && !w_at_start;
                w_missing = din_valid && !fsync &&  w_at_start;
                w_early   = din_valid &&  fsync && !w_at_start;
                if (w_missing) begin
                    w_next_state = HUNT;
                end
            end
            default: begin
                w_next_state = HUNT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
        end else if (w_restart) begin
            r_slot_cnt <= '0;
        end else if (w_word_done) begin
            r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Channel registers and status pulses.
    // Every frame in LOCK began on an fsync. Any error either restarts the
    // frame from slot 0 or drops back to HUNT. So reaching the end of slot 3
    // always means slots 0..3 arrived in order from an fsync.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_ch_word[k] <= '0;
            end
            r_ch_valid    <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_ch_valid[k] <= w_word_done && (r_slot_cnt == SLOT_W'(k));
                if (w_word_done && (r_slot_cnt == SLOT_W'(k))) begin
                    r_ch_word[k] <= w_word;
                end
            end
            r_frame_valid <= w_word_done && (r_slot_cnt == c_last_slot);
            r_sync_err    <= w_missing || w_early;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch_out
        assign ch_data[k*W +: W] = r_ch_word[k];
    end

    assign ch_valid    = r_ch_valid;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == LOCK);

endmodule : tdm_demux4_rx
`default_nettype wire
